// File: rtl/rsa_encrypt_stream.sv
// Modular exponentiation c = m^e mod n using interleaved shift-add multipliers; one message per handshake.
// Latency: KEYSIZE*(MSGSIZE+1)+2 edges from accept to out_valid (2 edges on the operand-error path).
// Backpressure: result held stable in DONE until out_ready; in_ready stays low until that handshake.
`timescale 1ns/1ps
module rsa_encrypt_stream #(
    parameter int MSGSIZE = 12,
    parameter int KEYSIZE = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MSGSIZE-1:0] msgIn,
    input  logic [KEYSIZE-1:0] key,
    input  logic [MSGSIZE-1:0] n,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MSGSIZE-1:0] msgOut,
    output logic               err
);

    localparam int CW = (MSGSIZE > 1) ? $clog2(MSGSIZE) : 1;
    localparam int KW = (KEYSIZE > 1) ? $clog2(KEYSIZE) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state;
    logic [MSGSIZE-1:0] m_q;
    logic [KEYSIZE-1:0] e_q;
    logic [MSGSIZE-1:0] n_q;
    logic [MSGSIZE-1:0] res;
    logic [MSGSIZE-1:0] base;
    logic [MSGSIZE-1:0] p1;
    logic [MSGSIZE-1:0] p2;
    logic [CW-1:0]      cnt;
    logic [KW-1:0]      k;

    logic [MSGSIZE-1:0] p1_nxt;
    logic [MSGSIZE-1:0] p2_nxt;
    logic [MSGSIZE-1:0] res_nxt;
    logic               chk_err;
    logic               last_mul;
    logic               last_bit;

    // One iteration of an MSB-first interleaved modular multiply.
    // p < md and b < md on entry, so 2p and p+b both fit in MSGSIZE+1 bits
    // and a single conditional subtract restores p < md. Both the add and the
    // subtracts are always evaluated and muxed, so timing is data independent.
    function automatic logic [MSGSIZE-1:0] mm_step(
        input logic [MSGSIZE-1:0] p,
        input logic               mbit,
        input logic [MSGSIZE-1:0] b,
        input logic [MSGSIZE-1:0] md
    );
        logic [MSGSIZE:0] nw;
        logic [MSGSIZE:0] t_dbl;
        logic [MSGSIZE:0] t_red;
        logic [MSGSIZE:0] t_add;
        logic [MSGSIZE:0] t_fin;
        nw    = {1'b0, md};
        t_dbl = {p, 1'b0};
        t_red = (t_dbl >= nw) ? (t_dbl - nw) : t_dbl;
        t_add = t_red + {1'b0, b};
        t_fin = (t_add >= nw) ? (t_add - nw) : t_add;
        if (!mbit) begin
            t_fin = t_red;
        end
        return t_fin[MSGSIZE-1:0];
    endfunction

    // Only IDLE accepts; reset forces in_ready low immediately.
    assign in_ready = (state == S_IDLE) && !rst;

    // Datapath next-values: both multipliers share the bit index and the modulus.
    always_comb begin
        p1_nxt   = mm_step(p1, res[cnt],  base, n_q);
        p2_nxt   = mm_step(p2, base[cnt], base, n_q);
        res_nxt  = e_q[k] ? p1 : res;
        chk_err  = (n_q < MSGSIZE'(2)) || (m_q >= n_q);
        last_mul = (cnt == '0);
        last_bit = (k == KW'(KEYSIZE - 1));
    end

    // Control FSM and all architectural state; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            m_q       <= '0;
            e_q       <= '0;
            n_q       <= '0;
            res       <= '0;
            base      <= '0;
            p1        <= '0;
            p2        <= '0;
            cnt       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            msgOut    <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        m_q   <= msgIn;
                        e_q   <= key;
                        n_q   <= n;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_err) begin
                        err       <= 1'b1;
                        msgOut    <= '0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        res   <= MSGSIZE'(1);
                        base  <= m_q;
                        k     <= '0;
                        cnt   <= CW'(MSGSIZE - 1);
                        p1    <= '0;
                        p2    <= '0;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    p1 <= p1_nxt;
                    p2 <= p2_nxt;
                    if (last_mul) begin
                        state <= S_STEP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_STEP: begin
                    res  <= res_nxt;
                    base <= p2;
                    if (last_bit) begin
                        msgOut    <= res_nxt;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        k     <= k + KW'(1);
                        cnt   <= CW'(MSGSIZE - 1);
                        p1    <= '0;
                        p2    <= '0;
                        state <= S_MUL;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        err       <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_encrypt_stream.sv
// Bench for rsa_encrypt_stream: table vectors, random vectors vs a square-and-multiply model,
// backpressure hold and mid-operation reset. Expected results travel through a scoreboard queue.
// All driving and sampling happens on the falling edge.
`timescale 1ns/1ps
module tb_rsa_encrypt_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] msgIn;
    logic [11:0] key;
    logic [11:0] nmod;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] msgOut;
    logic        err;

    typedef struct {
        logic [11:0] m;
        logic [11:0] e;
        logic [11:0] n;
        logic [11:0] c;
        logic        er;
        int          lat;
    } vec_t;

    typedef struct {
        logic [11:0] c;
        logic        er;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   tests;
    int   fails;
    int   cyc;
    int   acc_cyc;

    rsa_encrypt_stream #(.MSGSIZE(12), .KEYSIZE(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msgIn     (msgIn),
        .key       (key),
        .n         (nmod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .msgOut    (msgOut),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // MSB-first square-and-multiply reference, independent of the DUT's bit order.
    function automatic exp_t model(input int m, input int e, input int n);
        exp_t   x;
        longint r;
        if (n < 2 || m >= n) begin
            x.c = 12'd0; x.er = 1'b1; x.lat = 2;
        end else begin
            r = 1;
            for (int i = 11; i >= 0; i--) begin
                r = (r * r) % n;
                if (((e >> i) & 1) == 1) r = (r * m) % n;
            end
            x.c = 12'(r); x.er = 1'b0; x.lat = 158;
        end
        return x;
    endfunction

    // Called on a falling edge; returns on the falling edge right after the accept edge.
    task automatic send(input logic [11:0] m, input logic [11:0] e, input logic [11:0] nn,
                        input bit push, input exp_t x);
        int t;
        t = 0;
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_wait", 0, 1);
            return;
        end
        msgIn = m; key = e; nmod = nn; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        if (push) sb.push_back(x);
        check("in_ready_drop", in_ready, 0);
    endtask

    // Waits (bounded) for out_valid, pops and compares; completes the handshake if out_ready is high.
    task automatic recv(input string name);
        int   t;
        exp_t x;
        t = 0;
        while (!out_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            check({name, "_timeout"}, 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
            return;
        end
        x = sb.pop_front();
        check({name, "_msg"}, msgOut, x.c);
        check({name, "_err"}, err, x.er);
        check({name, "_lat"}, cyc - acc_cyc + 1, x.lat);
        if (out_ready) begin
            @(negedge clk);
            check({name, "_vld_clr"}, out_valid, 0);
            check({name, "_rdy_back"}, in_ready, 1);
        end
    endtask

    initial begin
        exp_t        x;
        logic [11:0] rm;
        logic [11:0] re;
        logic [11:0] rn;
        tests = 0; fails = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        msgIn = '0; key = '0; nmod = '0;

        tbl[0] = '{12'd65,   12'd17,   12'd3233, 12'd2790, 1'b0, 158};
        tbl[1] = '{12'd2790, 12'd2753, 12'd3233, 12'd65,   1'b0, 158};
        tbl[2] = '{12'd123,  12'd0,    12'd3233, 12'd1,    1'b0, 158};
        tbl[3] = '{12'd0,    12'd5,    12'd3233, 12'd0,    1'b0, 158};
        tbl[4] = '{12'd3233, 12'd7,    12'd3233, 12'd0,    1'b1, 2};
        tbl[5] = '{12'd0,    12'd3,    12'd1,    12'd0,    1'b1, 2};
        tbl[6] = '{12'd5,    12'd3,    12'd0,    12'd0,    1'b1, 2};
        tbl[7] = '{12'd2,    12'd3,    12'd11,   12'd8,    1'b0, 158};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_msgOut", msgOut, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        @(negedge clk);

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            x.c = tbl[i].c; x.er = tbl[i].er; x.lat = tbl[i].lat;
            send(tbl[i].m, tbl[i].e, tbl[i].n, 1'b1, x);
            recv($sformatf("tbl%0d", i));
        end

        // Random vectors against the reference model.
        for (int i = 0; i < 6; i++) begin
            rn = 12'($urandom_range(2, 4095));
            rm = 12'($urandom_range(0, int'(rn) - 1));
            re = 12'($urandom_range(0, 4095));
            x  = model(int'(rm), int'(re), int'(rn));
            send(rm, re, rn, 1'b1, x);
            recv($sformatf("rnd%0d", i));
        end

        // Backpressure: hold the result for 20 cycles while a new request knocks.
        out_ready = 1'b0;
        x.c = 12'd2790; x.er = 1'b0; x.lat = 158;
        send(12'd65, 12'd17, 12'd3233, 1'b1, x);
        recv("bp");
        msgIn = 12'd7; key = 12'd3; nmod = 12'd11; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold_vld", out_valid, 1);
            check("bp_hold_msg", msgOut, 2790);
            check("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bp_release_vld", out_valid, 0);
        check("bp_release_rdy", in_ready, 1);
        check("bp_release_err", err, 0);

        // Mid-operation reset aborts the transaction.
        x.c = 12'd0; x.er = 1'b0; x.lat = 0;
        send(12'd65, 12'd17, 12'd3233, 1'b0, x);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rst_vld", out_valid, 0);
        check("abort_rst_rdy", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rdy", in_ready, 1);
        check("abort_vld", out_valid, 0);
        check("abort_msg", msgOut, 0);
        @(negedge clk);
        x.c = 12'd8; x.er = 1'b0; x.lat = 158;
        send(12'd2, 12'd3, 12'd11, 1'b1, x);
        recv("after_abort");

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
